// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - sequencer state encoding and instruction opcodes
package exec_sequencer_pkg;

    localparam int OPC_W = 6;
    localparam int TMO_W = 8;

    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_MEM    = 3'd2,
        SEQ_MULDIV = 3'd3,
        SEQ_IRQ    = 3'd4,
        SEQ_ILLOP  = 3'd5,
        SEQ_FAULT  = 3'd6
    } seq_state_e;

    localparam logic [OPC_W-1:0] OP_LD     = 6'h18;
    localparam logic [OPC_W-1:0] OP_ST     = 6'h19;
    localparam logic [OPC_W-1:0] OP_JMP    = 6'h1B;
    localparam logic [OPC_W-1:0] OP_BEQ    = 6'h1C;
    localparam logic [OPC_W-1:0] OP_BNE    = 6'h1D;
    localparam logic [OPC_W-1:0] OP_LDR    = 6'h1F;
    localparam logic [OPC_W-1:0] OP_ADD    = 6'h20;
    localparam logic [OPC_W-1:0] OP_SUB    = 6'h21;
    localparam logic [OPC_W-1:0] OP_MUL    = 6'h22;
    localparam logic [OPC_W-1:0] OP_DIV    = 6'h23;
    localparam logic [OPC_W-1:0] OP_CMPEQ  = 6'h24;
    localparam logic [OPC_W-1:0] OP_CMPLT  = 6'h25;
    localparam logic [OPC_W-1:0] OP_CMPLE  = 6'h26;
    localparam logic [OPC_W-1:0] OP_AND    = 6'h28;
    localparam logic [OPC_W-1:0] OP_OR     = 6'h29;
    localparam logic [OPC_W-1:0] OP_XOR    = 6'h2A;
    localparam logic [OPC_W-1:0] OP_XNOR   = 6'h2B;
    localparam logic [OPC_W-1:0] OP_SHL    = 6'h2C;
    localparam logic [OPC_W-1:0] OP_SHR    = 6'h2D;
    localparam logic [OPC_W-1:0] OP_SRA    = 6'h2E;
    localparam logic [OPC_W-1:0] OP_ADDC   = 6'h30;
    localparam logic [OPC_W-1:0] OP_SUBC   = 6'h31;
    localparam logic [OPC_W-1:0] OP_MULC   = 6'h32;
    localparam logic [OPC_W-1:0] OP_DIVC   = 6'h33;
    localparam logic [OPC_W-1:0] OP_CMPEQC = 6'h34;
    localparam logic [OPC_W-1:0] OP_CMPLTC = 6'h35;
    localparam logic [OPC_W-1:0] OP_CMPLEC = 6'h36;
    localparam logic [OPC_W-1:0] OP_ANDC   = 6'h38;
    localparam logic [OPC_W-1:0] OP_ORC    = 6'h39;
    localparam logic [OPC_W-1:0] OP_XORC   = 6'h3A;
    localparam logic [OPC_W-1:0] OP_XNORC  = 6'h3B;
    localparam logic [OPC_W-1:0] OP_SHLC   = 6'h3C;
    localparam logic [OPC_W-1:0] OP_SHRC   = 6'h3D;
    localparam logic [OPC_W-1:0] OP_SRAC   = 6'h3E;

endpackage

// File: rtl/seq_op_class.sv
// rtl/seq_op_class.sv - combinational opcode classifier for the exec sequencer
module seq_op_class
    import exec_sequencer_pkg::*;
#(
    parameter int OP_W = OPC_W
) (
    input  logic [OP_W-1:0] op,
    output logic            is_mem,
    output logic            is_md,
    output logic            is_st,
    output logic            is_legal
);

    always_comb begin
        is_mem   = 1'b0;
        is_md    = 1'b0;
        is_st    = 1'b0;
        is_legal = 1'b1;
        case (op)
            OP_LD, OP_LDR: is_mem = 1'b1;
            OP_ST: begin
                is_mem = 1'b1;
                is_st  = 1'b1;
            end
            OP_MUL, OP_DIV, OP_MULC, OP_DIVC: is_md = 1'b1;
            OP_JMP, OP_BEQ, OP_BNE,
            OP_ADD, OP_SUB, OP_CMPEQ, OP_CMPLT, OP_CMPLE,
            OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_SHL, OP_SHR, OP_SRA,
            OP_ADDC, OP_SUBC, OP_CMPEQC, OP_CMPLTC, OP_CMPLEC,
            OP_ANDC, OP_ORC, OP_XORC, OP_XNORC, OP_SHLC, OP_SHRC, OP_SRAC: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle fetch/decode/execute sequencer with shared memory port
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int OP_W        = OPC_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [OP_W-1:0] op,
    input  logic            irq,
    input  logic            sup,
    input  logic            mem_ack,
    input  logic            md_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            ir_load,
    output logic            md_start,
    output logic            werf_en,
    output logic            pc_en,
    output logic            irq_take,
    output logic            illop,
    output logic            bus_fault,
    output logic [2:0]      state
);

    seq_state_e        state_q;
    logic              irq_pend_q;
    logic              md_first_q;
    logic [TMO_W-1:0]  tmo_q;

    logic is_mem, is_md, is_st, is_legal;
    logic in_req, tmo_hit, take_irq, alu_done;

    seq_op_class #(.OP_W(OP_W)) u_op_class (
        .op       (op),
        .is_mem   (is_mem),
        .is_md    (is_md),
        .is_st    (is_st),
        .is_legal (is_legal)
    );

    assign in_req   = (state_q == SEQ_FETCH) || (state_q == SEQ_MEM);
    // The cycle that would bring the count to MEM_TIMEOUT-1 faults unless mem_ack lands in it.
    assign tmo_hit  = in_req && !mem_ack && (tmo_q == TMO_W'(MEM_TIMEOUT - 2));
    assign take_irq = irq_pend_q && !sup;
    assign alu_done = !take_irq && !is_mem && !is_md && is_legal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEQ_FETCH;
            irq_pend_q <= 1'b0;
            md_first_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            irq_pend_q <= irq || (irq_pend_q && (state_q != SEQ_IRQ));
            tmo_q      <= (in_req && !mem_ack && !tmo_hit) ? tmo_q + 1'b1 : '0;
            md_first_q <= 1'b0;
            case (state_q)
                SEQ_FETCH: begin
                    if (mem_ack)      state_q <= SEQ_DECODE;
                    else if (tmo_hit) state_q <= SEQ_FAULT;
                end
                SEQ_DECODE: begin
                    if (take_irq)      state_q <= SEQ_IRQ;
                    else if (is_mem)   state_q <= SEQ_MEM;
                    else if (is_md) begin
                        state_q    <= SEQ_MULDIV;
                        md_first_q <= 1'b1;
                    end
                    else if (is_legal) state_q <= SEQ_FETCH;
                    else               state_q <= SEQ_ILLOP;
                end
                SEQ_MEM: begin
                    if (mem_ack)      state_q <= SEQ_FETCH;
                    else if (tmo_hit) state_q <= SEQ_FAULT;
                end
                SEQ_MULDIV: begin
                    if (md_done) state_q <= SEQ_FETCH;
                end
                default: state_q <= SEQ_FETCH;
            endcase
        end
    end

    // Outputs follow state; reset_n gates them so the port drops the moment reset asserts.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        md_start  = 1'b0;
        werf_en   = 1'b0;
        pc_en     = 1'b0;
        irq_take  = 1'b0;
        illop     = 1'b0;
        bus_fault = 1'b0;
        if (reset_n) begin
            case (state_q)
                SEQ_FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ack;
                end
                SEQ_DECODE: begin
                    werf_en = alu_done;
                    pc_en   = alu_done;
                end
                SEQ_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = is_st;
                    werf_en  = mem_ack && !is_st;
                    pc_en    = mem_ack;
                end
                SEQ_MULDIV: begin
                    md_start = md_first_q;
                    werf_en  = md_done;
                    pc_en    = md_done;
                end
                SEQ_IRQ: begin
                    irq_take = 1'b1;
                    werf_en  = 1'b1;
                    pc_en    = 1'b1;
                end
                SEQ_ILLOP: begin
                    illop   = 1'b1;
                    werf_en = 1'b1;
                    pc_en   = 1'b1;
                end
                SEQ_FAULT: begin
                    bus_fault = 1'b1;
                    illop     = 1'b1;
                    werf_en   = 1'b1;
                    pc_en     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = reset_n ? state_q : SEQ_FETCH;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed vector bench for exec_sequencer
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       irq, sup, mem_ack, md_done;
    logic       mem_req, mem_we, addr_sel, ir_load, md_start, werf_en, pc_en;
    logic       irq_take, illop, bus_fault;
    logic [2:0] dut_state;
    logic [9:0] dut_outs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exec_sequencer #(.MEM_TIMEOUT(16), .OP_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .irq       (irq),
        .sup       (sup),
        .mem_ack   (mem_ack),
        .md_done   (md_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .md_start  (md_start),
        .werf_en   (werf_en),
        .pc_en     (pc_en),
        .irq_take  (irq_take),
        .illop     (illop),
        .bus_fault (bus_fault),
        .state     (dut_state)
    );

    // Output order: req we asel irl mds werf pc irqt ill bf
    assign dut_outs = {mem_req, mem_we, addr_sel, ir_load, md_start,
                       werf_en, pc_en, irq_take, illop, bus_fault};

    localparam logic [5:0] LD = 6'h18, ST = 6'h19, ADD = 6'h20, MUL = 6'h22, UNDEF = 6'h00;
    localparam logic [9:0] O_NONE  = 10'b0000000000;
    localparam logic [9:0] O_FREQ  = 10'b1000000000;
    localparam logic [9:0] O_FACK  = 10'b1001000000;
    localparam logic [9:0] O_ALU   = 10'b0000011000;
    localparam logic [9:0] O_MWAIT = 10'b1010000000;
    localparam logic [9:0] O_LDACK = 10'b1010011000;
    localparam logic [9:0] O_STACK = 10'b1110001000;
    localparam logic [9:0] O_ILL   = 10'b0000011010;
    localparam logic [9:0] O_IRQ   = 10'b0000011100;
    localparam logic [9:0] O_FAULT = 10'b0000011011;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] op;
        logic       irq, sup, ack, done;
        logic [2:0] exp_state;
        logic [9:0] exp_outs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic r, input logic [5:0] o, input logic i,
                       input logic s, input logic a, input logic d,
                       input logic [2:0] st, input logic [9:0] ex);
        vecs.push_back('{n, r, o, i, s, a, d, st, ex});
    endtask

    task automatic check(input string n, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: state/outs got %b, expected %b", n, act, exp);
        end
    endtask

    task automatic step(input string n, input logic [2:0] st, input logic [9:0] ex);
        @(negedge clk);
        check(n, {dut_state, dut_outs}, {st, ex});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; op = ADD; irq = 1'b0; sup = 1'b0; mem_ack = 1'b0; md_done = 1'b0;

        add("reset",        0, ADD,   0, 0, 1, 0, 3'd0, O_NONE);
        add("add_fetch",    1, ADD,   0, 0, 1, 0, 3'd0, O_FACK);
        add("add_decode",   1, ADD,   0, 0, 1, 0, 3'd1, O_ALU);
        add("add_next_req", 1, ADD,   0, 0, 0, 1, 3'd0, O_FREQ);
        add("ld_fetch",     1, LD,    0, 0, 1, 0, 3'd0, O_FACK);
        add("ld_decode",    1, LD,    0, 0, 0, 0, 3'd1, O_NONE);
        add("ld_wait1",     1, LD,    0, 0, 0, 0, 3'd2, O_MWAIT);
        add("ld_wait2",     1, LD,    0, 0, 0, 0, 3'd2, O_MWAIT);
        add("ld_wait3",     1, LD,    0, 0, 0, 0, 3'd2, O_MWAIT);
        add("ld_ack",       1, LD,    0, 0, 1, 0, 3'd2, O_LDACK);
        add("st_fetch",     1, ST,    0, 0, 1, 0, 3'd0, O_FACK);
        add("st_decode",    1, ST,    0, 0, 0, 0, 3'd1, O_NONE);
        add("st_ack",       1, ST,    0, 0, 1, 0, 3'd2, O_STACK);
        add("ill_fetch",    1, UNDEF, 0, 0, 1, 0, 3'd0, O_FACK);
        add("ill_decode",   1, UNDEF, 0, 0, 0, 0, 3'd1, O_NONE);
        add("illop",        1, UNDEF, 0, 0, 1, 0, 3'd5, O_ILL);
        add("irq_ld_fetch", 1, LD,    0, 0, 1, 0, 3'd0, O_FACK);
        add("irq_ld_dec",   1, LD,    0, 0, 0, 0, 3'd1, O_NONE);
        add("irq_in_mem",   1, LD,    1, 0, 0, 0, 3'd2, O_MWAIT);
        add("irq_ld_ack",   1, LD,    0, 0, 1, 0, 3'd2, O_LDACK);
        add("irq_fetch",    1, ADD,   0, 0, 1, 0, 3'd0, O_FACK);
        add("irq_decode",   1, ADD,   0, 0, 0, 0, 3'd1, O_NONE);
        add("irq_take",     1, ADD,   0, 0, 0, 0, 3'd4, O_IRQ);
        add("post_irq_f",   1, ADD,   0, 0, 1, 0, 3'd0, O_FACK);
        add("pend_cleared", 1, ADD,   0, 0, 0, 0, 3'd1, O_ALU);
        add("sup_ld_fetch", 1, LD,    0, 1, 1, 0, 3'd0, O_FACK);
        add("sup_ld_dec",   1, LD,    0, 1, 0, 0, 3'd1, O_NONE);
        add("sup_irq_mem",  1, LD,    1, 1, 1, 0, 3'd2, O_LDACK);
        add("sup_fetch",    1, ADD,   0, 1, 1, 0, 3'd0, O_FACK);
        add("sup_masked",   1, ADD,   0, 1, 0, 0, 3'd1, O_ALU);
        add("unmask_fetch", 1, ADD,   0, 0, 1, 0, 3'd0, O_FACK);
        add("unmask_dec",   1, ADD,   0, 0, 0, 0, 3'd1, O_NONE);
        add("irq_held",     1, ADD,   1, 0, 0, 0, 3'd4, O_IRQ);
        add("held_fetch",   1, ADD,   0, 0, 1, 0, 3'd0, O_FACK);
        add("held_decode",  1, ADD,   0, 0, 0, 0, 3'd1, O_NONE);
        add("held_reenter", 1, ADD,   0, 0, 0, 0, 3'd4, O_IRQ);
        add("idle_fetch",   1, ADD,   0, 0, 0, 0, 3'd0, O_FREQ);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            reset_n = vecs[k].rst_n; op = vecs[k].op; irq = vecs[k].irq;
            sup = vecs[k].sup; mem_ack = vecs[k].ack; md_done = vecs[k].done;
            step(vecs[k].name, vecs[k].exp_state, vecs[k].exp_outs);
        end

        // MUL: md_done arrives 5 cycles after the start pulse
        op = MUL; mem_ack = 1'b1; irq = 1'b0; sup = 1'b0;
        step("mul_fetch", 3'd0, O_FACK);
        mem_ack = 1'b0;
        step("mul_decode", 3'd1, O_NONE);
        for (int k = 0; k < 6; k++) begin
            md_done = (k == 5);
            step($sformatf("mul_cyc%0d", k), 3'd3,
                 {4'b0000, k == 0, k == 5, k == 5, 3'b000});
        end
        md_done = 1'b0;
        step("mul_done_fetch", 3'd0, O_FREQ);

        // LD with no ack: 15 waiting cycles, then FAULT in the 16th
        op = LD; mem_ack = 1'b1;
        step("tmo_fetch", 3'd0, O_FACK);
        mem_ack = 1'b0;
        step("tmo_decode", 3'd1, O_NONE);
        for (int k = 1; k <= 15; k++) step($sformatf("tmo_wait%0d", k), 3'd2, O_MWAIT);
        step("tmo_fault", 3'd6, O_FAULT);

        // ack in the last possible cycle beats the timeout
        mem_ack = 1'b1;
        step("ackwin_fetch", 3'd0, O_FACK);
        mem_ack = 1'b0;
        step("ackwin_decode", 3'd1, O_NONE);
        for (int k = 1; k <= 14; k++) step($sformatf("ackwin_wait%0d", k), 3'd2, O_MWAIT);
        mem_ack = 1'b1;
        step("ackwin_ack", 3'd2, O_LDACK);

        // reset asserted in the middle of a MEM access
        step("rst_fetch", 3'd0, O_FACK);
        mem_ack = 1'b0;
        step("rst_decode", 3'd1, O_NONE);
        step("rst_mem", 3'd2, O_MWAIT);
        reset_n = 1'b0;
        #1;
        check("rst_mid_mem", {dut_state, dut_outs}, {3'd0, O_NONE});
        @(posedge clk);
        #1;
        check("rst_held", {dut_state, dut_outs}, {3'd0, O_NONE});
        reset_n = 1'b1;
        step("rst_release", 3'd0, O_FREQ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
